md_sequencer: RTL
=================

# md_sequencer

Iterative multiply/divide sequencer for the five-stage pipeline. It sits beside the ALU in the execute (X) stage and accepts `mul` (ALUop 00110) and `div` (ALUop 00111) from X. It stalls the front of the pipeline while a 32-iteration shift-add or restoring-divide datapath runs, then presents the result for one cycle so the X/M latch can capture it. Faults are reported with the rstatus codes already used by the control path: mul overflow = 4, div by zero = 5.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `ITER`, 32: iterations per operation. Must equal `WIDTH`.

Ports:
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `issue`  in  1: X holds a valid mul/div. Sampled only in IDLE.
- `op_div`  in  1: 0 = mul, 1 = div. Sampled with `issue`.
- `operand_a`  in  32: signed multiplicand or dividend.
- `operand_b`  in  32: signed multiplier or divisor.
- `dest_in`  in  5: destination register of the issuing instruction.
- `stall`  out  1: freeze PC, F/D and D/X. Hold X.
- `busy`  out  1: FSM not in IDLE.
- `result_valid`  out  1: one-cycle pulse; `result`, `result_dest` and `exception` are valid.
- `result`  out  32: product low word or quotient.
- `result_dest`  out  5: latched `dest_in`, or 30 when `exception` = 1.
- `exception`  out  1: overflow or divide-by-zero on this result.
- `exc_code`  out  32: 4 (mul overflow) or 5 (div by zero) when `exception` = 1; otherwise 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - With `issue` = 1: latch op, dest, sign_a, sign_b, |a|, |b|.
  - Clear the 6-bit iteration counter.
  - If div and b == 0: go to DONE with the divide-by-zero flag set. Otherwise go to RUN.
- RUN: one iteration per cycle. The counter increments; leave for DONE after the iteration with count = 31.
  - mul: unsigned shift-add on magnitudes into a 64-bit product register.
  - div: restoring division on magnitudes. One quotient bit per cycle, MSB first. 33-bit partial remainder.
- DONE: drive the result and pulse `result_valid`. Always return to IDLE next cycle. `issue` is ignored here because X still presents the same instruction.
- Magnitudes: |x| is computed in 33 bits, so |−2^31| = 2^31 is exact.
- mul result:
  - Negate the 64-bit product if sign_a ^ sign_b. `result` = low 32 bits.
  - Overflow when bits [63:31] of the signed product are not all equal. On overflow: `exception` = 1, `exc_code` = 4, `result` is still the low word.
- div result:
  - Quotient truncates toward zero. Negate if sign_a ^ sign_b. The remainder is discarded.
  - −2^31 / −1 yields 0x80000000 with no exception.
- div by zero: `result` = 0, `exception` = 1, `exc_code` = 5.
- When `exception` = 1, `result_dest` = 30 (rstatus); the pipeline writes `exc_code` there.

## Timing
- Reset, and every cycle `reset` = 1: state = IDLE, counter = 0, and every output is 0.
  - Reset mid-RUN or in DONE aborts the operation with no `result_valid`.
  - `reset` has priority over `issue`.
- `stall` = (IDLE & `issue`) | RUN. `stall` is combinational in the issue cycle and low in DONE and IDLE.
- Issue at cycle T (normal op):
  - RUN for T+1..T+32.
  - DONE at T+33, with `result_valid` = 1 in that cycle only.
  - `stall` is high for T..T+32, i.e. 33 cycles.
- Div by zero issued at T: DONE at T+1; `stall` is high at T only.
- `result`, `result_dest`, `exception` and `exc_code` are registered and valid only while `result_valid` = 1. They are 0 in all other cycles.
- Back-to-back: the next mul/div enters X at T+34 and is accepted (IDLE). No bubble beyond that is required.
- `busy` = 1 in RUN and DONE.

## Test plan
- mul 7 × −6: `stall` high 33 cycles; `result_valid` at T+33 with `result` = 0xFFFFFFD6, `exception` = 0, `result_dest` = `dest_in`.
- mul 0x00010000 × 0x00010000: `result` = 0, `exception` = 1, `exc_code` = 4, `result_dest` = 30. Also mul 0x80000000 × 1 → 0x80000000 with no exception.
- div −7 / 2 → 0xFFFFFFFD (−3). div −2^31 / −1 → 0x80000000, `exception` = 0.
- div 5 / 0 at T: `stall` high only at T; at T+1 `result` = 0, `exception` = 1, `exc_code` = 5, `result_dest` = 30.
- Reset asserted at T+10 of a mul: all outputs 0 at T+11, state IDLE, no `result_valid` ever. A new issue at T+12 completes normally at T+45.
- Back-to-back div then mul with `issue` held high through DONE:
  - Exactly one `result_valid` per instruction.
  - DONE does not re-accept the issue.
  - The second op's `stall` starts the cycle after DONE.

Source files
------------

// File: rtl/md_sequencer.sv
// Iterative 32-cycle multiply/divide unit beside the X-stage ALU.
// Stalls the front end while running, then pulses one registered result.
module md_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue,
  input  logic             op_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       dest_in,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_dest,
  output logic             exception,
  output logic [31:0]      exc_code
);

  localparam int          CNT_W    = 6;
  localparam logic [4:0]  RSTATUS  = 5'd30;
  localparam logic [31:0] EXC_OVF  = 32'd4;
  localparam logic [31:0] EXC_DIV0 = 32'd5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic       op_div;
    logic       sign_a;
    logic       sign_b;
    logic [4:0] dest;
  } md_req_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  md_req_t              req;
  logic [WIDTH:0]       mag_a, mag_b;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     rem, quo;

  logic                 rv_q, exc_q;
  logic [WIDTH-1:0]     res_q;
  logic [4:0]           dest_q;
  logic [31:0]          code_q;

  // Magnitudes in WIDTH+1 bits so |-2^(WIDTH-1)| is representable.
  logic [WIDTH:0] ext_a, ext_b, abs_a, abs_b;
  assign ext_a = {operand_a[WIDTH-1], operand_a};
  assign ext_b = {operand_b[WIDTH-1], operand_b};
  assign abs_a = ext_a[WIDTH] ? -ext_a : ext_a;
  assign abs_b = ext_b[WIDTH] ? -ext_b : ext_b;

  logic [WIDTH:0]       sum, rem_sh, trial;
  logic [2*WIDTH-1:0]   prod_nxt, sprod;
  logic [WIDTH-1:0]     rem_nxt, quo_nxt, squo;
  logic [WIDTH:0]       prod_hi;
  logic                 neg, ovf;
  logic [WIDTH-1:0]     fin_res;
  logic                 fin_exc;
  logic [4:0]           fin_dest;
  logic [31:0]          fin_code;

  always_comb begin
    neg = req.sign_a ^ req.sign_b;

    // Shift-add, LSB of multiplier first; multiplier lives in prod's low half.
    sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? mag_a : '0);
    prod_nxt = {sum, prod[WIDTH-1:1]};

    // Restoring divide: dividend shifts out of quo MSB-first into the remainder.
    rem_sh  = {rem, quo[WIDTH-1]};
    trial   = rem_sh - mag_b;
    rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

    sprod   = neg ? -prod_nxt : prod_nxt;
    prod_hi = sprod[2*WIDTH-1:WIDTH-1];
    ovf     = !((&prod_hi) | ~(|prod_hi));
    squo    = neg ? -quo_nxt : quo_nxt;

    fin_res  = req.op_div ? squo : sprod[WIDTH-1:0];
    fin_exc  = !req.op_div && ovf;
    fin_dest = fin_exc ? RSTATUS : req.dest;
    fin_code = fin_exc ? EXC_OVF : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      req    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
      rv_q   <= 1'b0;
      res_q  <= '0;
      dest_q <= '0;
      exc_q  <= 1'b0;
      code_q <= '0;
    end else begin
      rv_q   <= 1'b0;
      res_q  <= '0;
      dest_q <= '0;
      exc_q  <= 1'b0;
      code_q <= '0;
      case (state)
        IDLE: if (issue) begin
          req.op_div <= op_div;
          req.sign_a <= operand_a[WIDTH-1];
          req.sign_b <= operand_b[WIDTH-1];
          req.dest   <= dest_in;
          mag_a      <= abs_a;
          mag_b      <= abs_b;
          prod       <= {{WIDTH{1'b0}}, abs_b[WIDTH-1:0]};
          rem        <= '0;
          quo        <= abs_a[WIDTH-1:0];
          cnt        <= '0;
          if (op_div && operand_b == '0) begin
            state  <= DONE;
            rv_q   <= 1'b1;
            exc_q  <= 1'b1;
            code_q <= EXC_DIV0;
            dest_q <= RSTATUS;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (req.op_div) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
          end else begin
            prod <= prod_nxt;
          end
          if (cnt == CNT_W'(ITER - 1)) begin
            state  <= DONE;
            rv_q   <= 1'b1;
            res_q  <= fin_res;
            exc_q  <= fin_exc;
            dest_q <= fin_dest;
            code_q <= fin_code;
          end
        end
        // X still shows the finished instruction here, so issue is ignored.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Every output reads as zero in any cycle with reset high.
  assign stall        = !reset && ((state == IDLE && issue) || state == RUN);
  assign busy         = !reset && (state != IDLE);
  assign result_valid = !reset && rv_q;
  assign result       = reset ? '0 : res_q;
  assign result_dest  = reset ? '0 : dest_q;
  assign exception    = !reset && exc_q;
  assign exc_code     = reset ? '0 : code_q;

endmodule
